spi_frame_tx: RTL and testbench
===============================

# spi_frame_tx

Serial frame transmitter that drives the `rx` line of the 11-bit negedge-sampling SPI frame receiver. It accepts parallel words through a valid/ready handshake, buffers them in a small FIFO, and shifts them out LSB-first as a continuous, gap-free stream of fixed-length frames. Idle frames fill any gaps, so the receiver's free-running bit counter stays frame-aligned. `tx` changes only on the rising edge of `clk`, which gives the receiver's falling-edge sample half a clock of setup.

## Interface

Parameters:
- `WIDTH`, 11, bits per frame; must match the receiver frame length.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `IDLE_WORD`, 11'h000, frame content sent when the FIFO is empty.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  word to transmit.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a word (`level < DEPTH`).
- `tx`  out  1  serial data, registered; connects to receiver `rx`.
- `frame_start`  out  1  one-cycle pulse while `tx` carries bit 0 of a frame.
- `idle_frame`  out  1  current frame is `IDLE_WORD`, not popped data.
- `frame_count`  out  6  frames started, modulo 64.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation

- Push happens when `in_valid && in_ready`. There is no bypass: when `level == DEPTH`, `in_ready` is 0 even if a pop occurs in the same cycle.
- `bit_cnt` counts 0..WIDTH-1 and wraps to 0. A **load** occurs on every posedge where `bit_cnt` wraps to 0, and on the first posedge after `rst` deasserts.
- Load behaviour:
  - If registered `level > 0` before that edge: pop the FIFO head into the shift register and set `idle_frame` to 0.
  - Otherwise: load `IDLE_WORD` and set `idle_frame` to 1.
  - A word pushed on the load edge itself does not count. It waits for the next frame.
- `tx` outputs shift-register bit `bit_cnt`, LSB first. Frames are back-to-back with no gap bits.
- `frame_count` increments (wrapping 63 to 0) on every load, idle or data. It resets to 63, so the first frame reports 0.
- `level` is updated as +1 on push only, −1 on pop only, and unchanged on push with pop.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally.

States (2-state FSM):
- **RESET**: entered while `rst` = 1.
- **RUN**: entered on the first edge with `rst` = 0; that edge performs a load. The block stays in RUN until reset.

## Timing

- Reset values, on the edge where `rst` = 1:
  - `tx` = 0, `frame_start` = 0, `idle_frame` = 1, `frame_count` = 63, `level` = 0, `in_ready` = 0.
  - `bit_cnt` = 0, FIFO pointers = 0, shift register = `IDLE_WORD`.
- `in_ready` goes to 1 on the first cycle after reset deasserts.
- On the first RUN edge, `tx` = bit 0 of the loaded word, `frame_start` = 1, and `frame_count` = 0.
- Latency: a word accepted at edge t, with an empty FIFO and not on a load edge, starts at the next load edge after t. Its bit k appears on `tx` k cycles after that edge.
- `frame_start` is high exactly one cycle in every WIDTH cycles, unconditionally.
- Reset mid-frame: the frame is abandoned and the FIFO is flushed. The stream restarts at bit 0 on the first RUN edge, with no partial frame.

## Test plan

- **Reset**: hold `rst` 3 cycles -> all outputs at their reset values. Release -> `frame_start` = 1, `idle_frame` = 1, `frame_count` = 0, and `tx` shows `IDLE_WORD` bits for 11 cycles.
- **Single word**: push 11'h555 during an idle frame -> the next frame has `idle_frame` = 0 and `tx` = 1,0,1,0,1,0,1,0,1,0,1. The following frame is idle.
- **Fill FIFO**: push 11'h001, 11'h002, 11'h400, 11'h7FF on 4 consecutive edges while `tx` is mid-frame -> `level` = 4 and `in_ready` = 0; a fifth `in_valid` is not accepted. The 4 frames go out back-to-back in order with no idle frame between them, `level` decrements at each load, and `in_ready` rises the cycle after the first pop.
- **Push on load edge**: with an empty FIFO, assert `in_valid` exactly on a load edge -> that frame is idle. The word is sent in the next frame.
- **Counter wrap**: run 65 frames -> `frame_count` goes 0..63, then 0. `frame_start` period is exactly 11 cycles throughout.
- **Mid-frame reset**: with 2 words queued, assert `rst` during bit 5 -> `level` = 0 and `tx` = 0. After release, an idle frame starts and the queued words are never transmitted.

Source files
------------

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: buffered LSB-first serial frame transmitter.
// Emits a continuous stream of WIDTH-bit frames. Each frame carries the FIFO
// head, or IDLE_WORD when the FIFO is empty, so the downstream receiver's
// free-running bit counter stays frame-aligned.
module spi_frame_tx #(
   parameter int              WIDTH     = 11,
   parameter int              DEPTH     = 4,
   parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     tx,
   output logic                     frame_start,
   output logic                     idle_frame,
   output logic [5:0]               frame_count,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic {
      S_RESET,
      S_RUN
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic               tx_q, tx_d;
   logic               frame_start_q, frame_start_d;
   logic               idle_frame_q, idle_frame_d;
   logic [5:0]         frame_count_q, frame_count_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];

   logic               load;
   logic               push;
   logic               pop;

   // Handshake: no bypass, a full FIFO refuses even when a pop is due.
   assign in_ready    = (state_q == S_RUN) && (level_q < LVL_W'(DEPTH));
   assign push        = in_valid && in_ready;

   assign tx          = tx_q;
   assign frame_start = frame_start_q;
   assign idle_frame  = idle_frame_q;
   assign frame_count = frame_count_q;
   assign level       = level_q;

   // Next-state: frame sequencing, FIFO bookkeeping and serial output bit.
   always_comb begin
      state_d       = S_RUN;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      frame_start_d = 1'b0;
      idle_frame_d  = idle_frame_q;
      frame_count_d = frame_count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      level_d       = level_q;

      load = (state_q == S_RESET) || (bit_cnt_q == CNT_W'(WIDTH - 1));
      pop  = load && (level_q != '0);

      if (load) begin
         bit_cnt_d     = '0;
         frame_start_d = 1'b1;
         frame_count_d = frame_count_q + 6'd1;
         if (pop) begin
            shift_d      = mem_q[rd_ptr_q];
            idle_frame_d = 1'b0;
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
         end else begin
            shift_d      = IDLE_WORD;
            idle_frame_d = 1'b1;
         end
      end else begin
         bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      tx_d = shift_d[bit_cnt_d];
   end

   // State register with synchronous reset; reset abandons the frame and flushes the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_RESET;
         bit_cnt_q     <= '0;
         shift_q       <= IDLE_WORD;
         tx_q          <= 1'b0;
         frame_start_q <= 1'b0;
         idle_frame_q  <= 1'b1;
         frame_count_q <= 6'd63;
         level_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         tx_q          <= tx_d;
         frame_start_q <= frame_start_d;
         idle_frame_q  <= idle_frame_d;
         frame_count_q <= frame_count_d;
         level_q       <= level_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // FIFO storage write port; contents need no reset since pointers do.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Testbench for spi_frame_tx: queue-based reference model plus scoreboard monitor.
module tb_spi_frame_tx;

   localparam int          WIDTH     = 11;
   localparam int          DEPTH     = 4;
   localparam logic [10:0] IDLE_WORD = 11'h000;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        tx;
   logic        frame_start;
   logic        idle_frame;
   logic [5:0]  frame_count;
   logic [2:0]  level;

   always #5 clk = ~clk;

   spi_frame_tx #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .IDLE_WORD(IDLE_WORD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .tx(tx),
      .frame_start(frame_start),
      .idle_frame(idle_frame),
      .frame_count(frame_count),
      .level(level)
   );

   typedef struct {
      logic        idle;
      logic [10:0] word;
      int          fc;
   } frame_t;

   // Reference model state: accepted words and the frames they must become.
   logic [10:0] mq[$];
   frame_t      exp_frames[$];
   bit          m_rst     = 1'b0;
   bit          m_running = 1'b0;
   int          m_pos     = 0;
   int          m_fc      = 63;

   int tests  = 0;
   int failed = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: frames are WIDTH edges long, the first RUN edge starts one, and a
   // frame takes the oldest word accepted strictly before its start edge.
   always @(posedge clk) begin
      bit     ld;
      bit     acc;
      frame_t f;
      if (rst) begin
         mq.delete();
         exp_frames.delete();
         m_rst     = 1'b1;
         m_running = 1'b0;
         m_pos     = 0;
         m_fc      = 63;
      end else begin
         ld  = !m_running || (m_pos == WIDTH - 1);
         acc = in_valid && m_running && (mq.size() < DEPTH);
         if (ld) begin
            m_pos = 0;
            m_fc  = (m_fc + 1) % 64;
            if (mq.size() > 0) begin
               f.idle = 1'b0;
               f.word = mq.pop_front();
            end else begin
               f.idle = 1'b1;
               f.word = IDLE_WORD;
            end
            f.fc = m_fc;
            exp_frames.push_back(f);
         end else begin
            m_pos++;
         end
         if (acc) mq.push_back(in_data);
         m_rst     = 1'b0;
         m_running = 1'b1;
      end
   end

   // Monitor: on each DUT frame_start pop the expected frame, then check its bits.
   frame_t cur;
   bit     has_cur  = 1'b0;
   int     bitk     = 0;
   int     since_fs = 0;
   bit     first    = 1'b1;

   always @(negedge clk) begin
      if (m_rst) begin
         chk("rst_tx", tx, 0);
         chk("rst_frame_start", frame_start, 0);
         chk("rst_idle_frame", idle_frame, 1);
         chk("rst_frame_count", frame_count, 63);
         chk("rst_level", level, 0);
         chk("rst_in_ready", in_ready, 0);
         has_cur  = 1'b0;
         since_fs = 0;
         first    = 1'b1;
      end else if (m_running) begin
         chk("level", level, mq.size());
         chk("in_ready", in_ready, int'(mq.size() < DEPTH));
         chk("frame_count", frame_count, m_fc);
         since_fs++;
         if (frame_start) begin
            if (!first) chk("fs_period", since_fs, WIDTH);
            first    = 1'b0;
            since_fs = 0;
            chk("sb_depth", exp_frames.size(), 1);
            if (exp_frames.size() > 0) begin
               cur     = exp_frames.pop_front();
               has_cur = 1'b1;
               bitk    = 0;
               chk("idle_frame", idle_frame, cur.idle);
               chk("frame_fc", frame_count, cur.fc);
            end
         end else if (since_fs > WIDTH) begin
            chk("fs_missing", since_fs, WIDTH);
            since_fs = 0;
            first    = 1'b1;
         end
         if (has_cur && bitk < WIDTH) begin
            chk("tx_bit", tx, cur.word[bitk]);
            bitk++;
         end
      end
   end

   // Wait until tx carries bit p of the current frame (bounded).
   task automatic wait_pos(input int p);
      for (int i = 0; i < 4 * WIDTH; i++) begin
         @(negedge clk);
         if (m_running && !rst && m_pos == p) return;
      end
      tests++;
      failed++;
      $display("FAIL wait_pos: position %0d not reached at %0t", p, $time);
   endtask

   logic [10:0] fill_words [5];

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      fill_words[0] = 11'h001;
      fill_words[1] = 11'h002;
      fill_words[2] = 11'h400;
      fill_words[3] = 11'h7FF;
      fill_words[4] = 11'h123;

      // Reset for three edges, then idle frames.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (WIDTH + 2) @(negedge clk);

      // Single word mid idle frame.
      wait_pos(3);
      in_valid = 1'b1;
      in_data  = 11'h555;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3 * WIDTH) @(negedge clk);

      // Fill FIFO on consecutive edges; the fifth is refused.
      wait_pos(2);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = fill_words[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (6 * WIDTH) @(negedge clk);

      // Push exactly on a load edge with an empty FIFO.
      wait_pos(WIDTH - 1);
      in_valid = 1'b1;
      in_data  = 11'h2A5;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3 * WIDTH) @(negedge clk);

      // Frame counter wrap over more than 64 frames.
      repeat (66 * WIDTH) @(negedge clk);

      // Mid-frame reset with two words queued.
      wait_pos(0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 11'h3C3;
      @(negedge clk);
      in_data  = 11'h0F0;
      @(negedge clk);
      in_valid = 1'b0;
      wait_pos(5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3 * WIDTH) @(negedge clk);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         in_valid = ($urandom_range(0, 2) == 0);
         in_data  = 11'($urandom);
         rst      = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      repeat (3 * WIDTH) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
